// File: rtl/polepositionsoc_pio_pkg.sv
// polepositionsoc_pio_pkg: register map and pulse FSM states shared by the USB control PIO.
package polepositionsoc_pio_pkg;
  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_OUTSET    = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR  = 3'd5;
  localparam logic [2:0] ADDR_PULSE_LEN = 3'd6;
  localparam logic [2:0] ADDR_PULSE     = 3'd7;
  typedef enum logic {IDLE, PULSE} state_t;
endpackage

// File: rtl/usb_pio_pulse_timer.sv
// usb_pio_pulse_timer: holds busy for max(len,1) cycles after start; start is ignored while busy.
module usb_pio_pulse_timer
  import polepositionsoc_pio_pkg::*;
#(
  parameter int PULSE_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [PULSE_W-1:0] len,
  output logic               busy
);
  state_t             state_q, state_d;
  logic [PULSE_W-1:0] cnt_q, cnt_d;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE) begin
      if (start) begin
        state_d = PULSE;
        cnt_d   = (len == '0) ? '0 : len - PULSE_W'(1);
      end
    end else if (cnt_q == '0) begin
      state_d = IDLE;
    end else begin
      cnt_d = cnt_q - PULSE_W'(1);
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  assign busy = (state_q == PULSE);
endmodule

// File: rtl/polepositionsoc_usb_ctrl_pio.sv
// polepositionsoc_usb_ctrl_pio: Avalon-MM output PIO with set/clear and a hardware-timed XOR pulse.
module polepositionsoc_usb_ctrl_pio
  import polepositionsoc_pio_pkg::*;
#(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               PULSE_W     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [2:0]       address,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);
  logic               wr, busy, start;
  logic [WIDTH-1:0]   wd, data_q, data_d, mask_q, mask_d;
  logic [PULSE_W-1:0] len_q, len_d;
  logic [31:0]        rd_q, rd_d;
  always_comb begin
    wr     = chipselect & ~write_n;
    wd     = writedata[WIDTH-1:0];
    start  = wr && address == ADDR_PULSE && !busy;
    data_d = (wr && address == ADDR_DATA)     ? wd :
             (wr && address == ADDR_OUTSET)   ? data_q | wd :
             (wr && address == ADDR_OUTCLEAR) ? data_q & ~wd : data_q;
    len_d  = (wr && address == ADDR_PULSE_LEN) ? writedata[PULSE_W-1:0] : len_q;
    // mask only matters while busy; it drops to zero once the pulse has ended
    mask_d = start ? wd : busy ? mask_q : '0;
    rd_d   = (address == ADDR_DATA)      ? 32'(data_q) :
             (address == ADDR_PULSE_LEN) ? 32'(len_q) :
             (address == ADDR_PULSE)     ? 32'(busy) : '0;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= RESET_VALUE;
      mask_q <= '0;
      len_q  <= PULSE_W'(1);
      rd_q   <= '0;
    end else begin
      data_q <= data_d;
      mask_q <= mask_d;
      len_q  <= len_d;
      rd_q   <= rd_d;
    end
  end
  usb_pio_pulse_timer #(.PULSE_W(PULSE_W)) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .len    (len_q),
    .busy   (busy)
  );
  assign readdata = rd_q;
  assign out_port = data_q ^ (busy ? mask_q : '0);
endmodule

// File: tb/tb_polepositionsoc_usb_ctrl_pio.sv
// tb_polepositionsoc_usb_ctrl_pio: directed and random checks against a cycle-level register/pulse model.
module tb_polepositionsoc_usb_ctrl_pio;
  logic        clk = 0, reset_n = 0, chipselect = 0, write_n = 1;
  logic [2:0]  address = 0;
  logic [31:0] writedata = 0, readdata;
  logic [3:0]  out_port;
  int n_chk = 0, n_fail = 0;

  logic [3:0]  m_data, m_mask;
  logic [15:0] m_len;
  int          m_left;
  logic [31:0] m_rd;

  polepositionsoc_usb_ctrl_pio #(.WIDTH(4), .RESET_VALUE(4'h2), .PULSE_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .write_n(write_n),
    .address(address), .writedata(writedata), .readdata(readdata), .out_port(out_port)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] exp_out();
    return m_data ^ (m_left > 0 ? m_mask : 4'h0);
  endfunction

  task automatic model_reset();
    m_data = 4'h2; m_mask = 0; m_len = 16'd1; m_left = 0; m_rd = 0;
  endtask

  task automatic step(input logic c, input logic w, input logic [2:0] a, input logic [31:0] d);
    chipselect = c; write_n = ~w; address = a; writedata = d;
    @(posedge clk);
    m_rd = (a == 0) ? {28'd0, m_data} : (a == 6) ? {16'd0, m_len} : (a == 7) ? 32'(m_left > 0) : 32'd0;
    if (m_left > 0) m_left--;
    else if (c && w && a == 7) begin
      m_mask = d[3:0];
      m_left = (m_len == 0) ? 1 : int'(m_len);
    end
    if (c && w) begin
      if (a == 0) m_data = d[3:0];
      else if (a == 4) m_data = m_data | d[3:0];
      else if (a == 5) m_data = m_data & ~d[3:0];
      else if (a == 6) m_len = d[15:0];
    end
    #1;
    chipselect = 0; write_n = 1;
  endtask

  task automatic test_reset();
    model_reset();
    #12;
    n_chk++; if (out_port !== 4'h2) begin n_fail++; $display("FAIL reset_out got %h exp 2", out_port); end
    n_chk++; if (readdata !== 32'd0) begin n_fail++; $display("FAIL reset_rd got %h exp 0", readdata); end
    @(negedge clk); reset_n = 1;
    step(0, 0, 6, 0);
    n_chk++; if (readdata !== 32'd1) begin n_fail++; $display("FAIL reset_len got %h exp 1", readdata); end
    step(0, 0, 7, 0);
    n_chk++; if (readdata !== 32'd0) begin n_fail++; $display("FAIL reset_busy got %h exp 0", readdata); end
  endtask

  task automatic test_data();
    step(1, 1, 0, 32'hA);
    n_chk++; if (out_port !== 4'hA) begin n_fail++; $display("FAIL data_out got %h exp a", out_port); end
    step(0, 0, 0, 0);
    n_chk++; if (readdata !== 32'hA) begin n_fail++; $display("FAIL data_rd got %h exp a", readdata); end
    step(1, 1, 0, 32'hFFFF_FFFA);
    step(0, 0, 0, 0);
    n_chk++; if (readdata !== 32'hA) begin n_fail++; $display("FAIL data_wide got %h exp a", readdata); end
  endtask

  task automatic test_set_clear();
    step(1, 1, 4, 32'h5);
    n_chk++; if (out_port !== 4'hF) begin n_fail++; $display("FAIL outset got %h exp f", out_port); end
    step(1, 1, 5, 32'h3);
    n_chk++; if (out_port !== 4'hC) begin n_fail++; $display("FAIL outclear got %h exp c", out_port); end
    step(0, 0, 4, 0);
    n_chk++; if (readdata !== 32'd0) begin n_fail++; $display("FAIL rd_outset got %h exp 0", readdata); end
    step(0, 0, 5, 0);
    n_chk++; if (readdata !== 32'd0) begin n_fail++; $display("FAIL rd_outclear got %h exp 0", readdata); end
  endtask

  task automatic test_pulse();
    step(1, 1, 6, 32'd3);
    step(1, 1, 7, 32'h1);
    for (int i = 0; i < 5; i++) begin
      n_chk++; if (out_port !== (i < 3 ? 4'hD : 4'hC)) begin n_fail++; $display("FAIL pulse_out cyc %0d got %h exp %h", i, out_port, (i < 3 ? 4'hD : 4'hC)); end
      step(0, 0, 7, 0);
      n_chk++; if (readdata !== m_rd) begin n_fail++; $display("FAIL pulse_busy cyc %0d got %h exp %h", i, readdata, m_rd); end
    end
  endtask

  task automatic test_back_to_back();
    int hi;
    step(1, 1, 6, 32'd0);
    step(1, 1, 7, 32'h8);
    n_chk++; if (out_port !== 4'h4) begin n_fail++; $display("FAIL len0_on got %h exp 4", out_port); end
    step(0, 0, 0, 0);
    n_chk++; if (out_port !== 4'hC) begin n_fail++; $display("FAIL len0_off got %h exp c", out_port); end
    step(1, 1, 6, 32'd5);
    step(1, 1, 7, 32'h8);
    hi = 1;
    step(1, 1, 7, 32'h8);
    if (out_port === 4'h4) hi++;
    step(1, 1, 0, 32'h0);
    n_chk++; if (out_port !== 4'h8) begin n_fail++; $display("FAIL mid_data got %h exp 8", out_port); end
    if (out_port === 4'h8) hi++;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 7, 0);
      if (out_port === 4'h8) hi++;
    end
    n_chk++; if (hi !== 5) begin n_fail++; $display("FAIL retrig_len got %0d exp 5", hi); end
    n_chk++; if (out_port !== exp_out()) begin n_fail++; $display("FAIL retrig_end got %h exp %h", out_port, exp_out()); end
  endtask

  task automatic test_reset_mid_pulse();
    step(1, 1, 0, 32'hC);
    step(1, 1, 6, 32'd10);
    step(1, 1, 7, 32'h3);
    step(0, 0, 0, 0);
    n_chk++; if (out_port !== 4'hF) begin n_fail++; $display("FAIL pre_reset got %h exp f", out_port); end
    reset_n = 0;
    #1;
    model_reset();
    n_chk++; if (out_port !== 4'h2) begin n_fail++; $display("FAIL async_reset got %h exp 2", out_port); end
    @(negedge clk); reset_n = 1;
    step(0, 0, 7, 0);
    n_chk++; if (readdata !== 32'd0) begin n_fail++; $display("FAIL post_reset_idle got %h exp 0", readdata); end
    step(1, 1, 7, 32'h1);
    n_chk++; if (out_port !== 4'h3) begin n_fail++; $display("FAIL post_reset_trig got %h exp 3", out_port); end
    step(0, 0, 0, 0);
    n_chk++; if (out_port !== 4'h2) begin n_fail++; $display("FAIL post_reset_end got %h exp 2", out_port); end
  endtask

  task automatic test_random();
    logic [2:0] a;
    logic [31:0] d;
    for (int i = 0; i < 400; i++) begin
      a = 3'($urandom_range(0, 7));
      d = $urandom;
      if (a == 6) d = $urandom_range(0, 6);
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), a, d);
      n_chk++; if (out_port !== exp_out()) begin n_fail++; $display("FAIL rand_out %0d got %h exp %h", i, out_port, exp_out()); end
      n_chk++; if (readdata !== m_rd) begin n_fail++; $display("FAIL rand_rd %0d got %h exp %h", i, readdata, m_rd); end
    end
  endtask

  initial begin
    test_reset();
    test_data();
    test_set_clear();
    test_pulse();
    test_back_to_back();
    test_reset_mid_pulse();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
